// File: rtl/pc_tx_uart_pkg.sv
// pc_tx_uart_pkg
//   Shared definitions for the PC UART path: serializer state encodings,
//   default baud divisor and the PC frame header bytes (shared with the RX
//   parser and benches).
package pc_tx_uart_pkg;

  // Serializer states; encodings are fixed so RX/debug tooling can decode them.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4
  } tx_state_e;

  // 100 MHz / 115200 baud.
  localparam int unsigned PC_UART_BAUD_DIV = 868;

  // PC frame header, in wire order.
  localparam logic [7:0] PC_HDR_0 = 8'hEF;
  localparam logic [7:0] PC_HDR_1 = 8'h91;
  localparam logic [7:0] PC_HDR_2 = 8'h19;
  localparam logic [7:0] PC_HDR_3 = 8'hFE;

  // clk_sys cycles between start bits when bytes go out back to back
  // (start + 8 data + stop bits, plus one IDLE and one LOAD cycle).
  function automatic int unsigned pc_uart_byte_cycles(input int unsigned baud_div,
                                                      input int unsigned stop_bits);
    return (9 + stop_bits) * baud_div + 2;
  endfunction

endpackage

// File: rtl/pc_tx_fifo.sv
// pc_tx_fifo
//   Single-clock synchronous byte FIFO with registered read data and
//   registered full/empty/level flags.
// Ports:
//   clk_sys, rst       clock, synchronous active-high reset
//   wr_en, wr_data     write strobe/data; ignored while full
//   rd_en              read strobe; ignored while empty
//   rd_data            byte popped by the previous accepted read
//   full, empty, level occupancy, all registered
module pc_tx_fifo #(
  parameter int unsigned FIFO_DEPTH = 512,
  parameter int unsigned FIFO_AW    = 9
) (
  input  logic               clk_sys,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [7:0]         wr_data,
  input  logic               rd_en,
  output logic [7:0]         rd_data,
  output logic               full,
  output logic               empty,
  output logic [FIFO_AW:0]   level
);

  logic [7:0]         mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               wr_ok;
  logic               rd_ok;
  logic [FIFO_AW:0]   level_nxt;

  // Gating uses the flags registered at the start of the cycle, so a write
  // while full is dropped even if a read frees a slot in the same cycle.
  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;

  always_comb begin
    level_nxt = level;
    if (wr_ok && !rd_ok)
      level_nxt = level + (FIFO_AW+1)'(1);
    else if (!wr_ok && rd_ok)
      level_nxt = level - (FIFO_AW+1)'(1);
  end

  // Storage carries no reset; only pointers and flags define contents.
  always_ff @(posedge clk_sys) begin
    if (wr_ok)
      mem[wr_ptr] <= wr_data;
  end

  // Pointers are FIFO_AW wide, so they wrap modulo FIFO_DEPTH for free.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
      level   <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
    end else begin
      if (wr_ok)
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (rd_ok) begin
        rd_ptr  <= rd_ptr + FIFO_AW'(1);
        rd_data <= mem[rd_ptr];
      end
      level <= level_nxt;
      full  <= (level_nxt == (FIFO_AW+1)'(FIFO_DEPTH));
      empty <= (level_nxt == '0);
    end
  end

endmodule

// File: rtl/pc_tx_uart.sv
// pc_tx_uart
//   Last stage of the PC transmit path. Buffers framer bytes in a FIFO and
//   shifts them out as 8N1/8N2, LSB first.
// Ports:
//   clk_sys           system clock
//   rst               synchronous active-high reset (abandons a byte in flight)
//   pc_tx_data        byte from the framer
//   pc_tx_data_valid  byte strobe, no backpressure
//   tx_en             allows the serializer to start a new byte
//   tx_ovf_clr        one-cycle clear of tx_ovf
//   uart_txd          serial line, idle high, registered
//   tx_busy           FIFO holds data or a byte is in flight (registered)
//   fifo_level        bytes currently buffered
//   tx_ovf            sticky: a byte was dropped because the FIFO was full
module pc_tx_uart
  import pc_tx_uart_pkg::*;
#(
  parameter int unsigned U_DLY      = 1,
  parameter int unsigned FIFO_DEPTH = 512,
  parameter int unsigned FIFO_AW    = 9,
  parameter int unsigned BAUD_DIV   = PC_UART_BAUD_DIV,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic               clk_sys,
  input  logic               rst,
  input  logic [7:0]         pc_tx_data,
  input  logic               pc_tx_data_valid,
  input  logic               tx_en,
  input  logic               tx_ovf_clr,
  output logic               uart_txd,
  output logic               tx_busy,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               tx_ovf
);

  localparam int unsigned BCW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  // U_DLY is accepted as a parameter; all sequential assignments here are
  // zero-delay.
  logic u_dly_unused;
  assign u_dly_unused = (U_DLY != 0);

  tx_state_e          state;
  logic [7:0]         shift;
  logic [BCW-1:0]     baud_cnt;
  logic [2:0]         bit_cnt;
  logic               baud_end;
  logic               fifo_full;
  logic               fifo_empty;
  logic               rd_en;
  logic [7:0]         rd_data;
  logic               drop;

  pc_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .FIFO_AW    (FIFO_AW)
  ) u_fifo (
    .clk_sys (clk_sys),
    .rst     (rst),
    .wr_en   (pc_tx_data_valid),
    .wr_data (pc_tx_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Pop is issued straight from IDLE so the registered FIFO data is ready
  // exactly when LOAD samples it.
  assign rd_en    = (state == ST_IDLE) & tx_en & ~fifo_empty;
  assign baud_end = (baud_cnt == BCW'(BAUD_DIV - 1));
  assign drop     = pc_tx_data_valid & fifo_full;

  // Set has priority over clear so a drop in the clear cycle is not lost.
  always_ff @(posedge clk_sys) begin
    if (rst)
      tx_ovf <= 1'b0;
    else if (drop)
      tx_ovf <= 1'b1;
    else if (tx_ovf_clr)
      tx_ovf <= 1'b0;
  end

  // Serializer. uart_txd is driven from the current state, so the pin trails
  // the FSM by one cycle uniformly and no FSM decode reaches the pad.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state    <= ST_IDLE;
      shift    <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      uart_txd <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      tx_busy <= (fifo_level != '0) | (state != ST_IDLE);

      case (state)
        ST_START: uart_txd <= 1'b0;
        ST_DATA:  uart_txd <= shift[0];
        default:  uart_txd <= 1'b1;
      endcase

      case (state)
        ST_IDLE: begin
          if (rd_en)
            state <= ST_LOAD;
        end
        ST_LOAD: begin
          shift    <= rd_data;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          state    <= ST_START;
        end
        ST_START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + BCW'(1);
          end
        end
        ST_DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            shift    <= {1'b0, shift[7:1]};
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
              state   <= ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + BCW'(1);
          end
        end
        ST_STOP: begin
          // bit_cnt is reused to count stop bits.
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'(STOP_BITS - 1)) begin
              bit_cnt <= '0;
              state   <= ST_IDLE;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + BCW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_tx_uart.sv
// tb_pc_tx_uart
//   Scoreboard bench: stimulus pushes the bytes the FIFO should accept into
//   exp_q; an independent line monitor decodes uart_txd frames and pops.
module tb_pc_tx_uart;
  import pc_tx_uart_pkg::*;

  localparam int BD    = 4;
  localparam int SB    = 1;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int FRAME = (10 + SB - 1) * BD + 2;   // start-to-start, back to back

  logic          clk_sys = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    pc_tx_data = '0;
  logic          pc_tx_data_valid = 1'b0;
  logic          tx_en = 1'b0;
  logic          tx_ovf_clr = 1'b0;
  logic          uart_txd;
  logic          tx_busy;
  logic [AW:0]   fifo_level;
  logic          tx_ovf;

  pc_tx_uart #(
    .U_DLY(1), .FIFO_DEPTH(DEPTH), .FIFO_AW(AW), .BAUD_DIV(BD), .STOP_BITS(SB)
  ) dut (
    .clk_sys          (clk_sys),
    .rst              (rst),
    .pc_tx_data       (pc_tx_data),
    .pc_tx_data_valid (pc_tx_data_valid),
    .tx_en            (tx_en),
    .tx_ovf_clr       (tx_ovf_clr),
    .uart_txd         (uart_txd),
    .tx_busy          (tx_busy),
    .fifo_level       (fifo_level),
    .tx_ovf           (tx_ovf)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int         n_chk = 0;
  int         n_pass = 0;
  logic [7:0] exp_q[$];
  int         starts[$];
  int         abort_cnt = 0;
  bit         mon_busy = 0;
  int         low_cnt = 0;

  always @(negedge clk_sys) if (uart_txd === 1'b0) low_cnt <= low_cnt + 1;

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, req, req);
  endtask

  // ---------------- line monitor ----------------
  logic [7:0] m_b;
  bit         m_ok;
  int         m_ab0;
  logic [7:0] m_exp;

  initial begin : monitor
    forever begin
      @(negedge clk_sys);
      if (uart_txd === 1'b0) begin
        mon_busy = 1;
        m_ab0    = abort_cnt;
        m_ok     = 1;
        m_b      = '0;
        starts.push_back(cyc);
        for (int k = 1; k < BD; k++) begin
          @(negedge clk_sys); if (uart_txd !== 1'b0) m_ok = 0;
        end
        for (int i = 0; i < 8; i++)
          for (int k = 0; k < BD; k++) begin
            @(negedge clk_sys);
            if (k == 0) m_b[i] = uart_txd;
            else if (uart_txd !== m_b[i]) m_ok = 0;
          end
        for (int k = 0; k < SB * BD; k++) begin
          @(negedge clk_sys); if (uart_txd !== 1'b1) m_ok = 0;
        end
        if (abort_cnt == m_ab0) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_frame: got byte 0x%0h, expected no frame", m_b);
          end else begin
            m_exp = exp_q.pop_front();
            chk("frame_byte", int'(m_b), int'(m_exp));
            chk("frame_shape", int'(m_ok), 1);
          end
        end
        mon_busy = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic put(input logic [7:0] d, input bit acc);
    @(negedge clk_sys);
    pc_tx_data = d; pc_tx_data_valid = 1'b1;
    if (acc) exp_q.push_back(d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_sys);
      pc_tx_data_valid = 1'b0; tx_ovf_clr = 1'b0;
    end
  endtask

  task automatic wait_drain(input string nm, input int budget);
    int i;
    i = 0;
    while (i < budget && (exp_q.size() != 0 || mon_busy || tx_busy !== 1'b0)) begin
      @(negedge clk_sys); i++;
    end
    chk(nm, int'(i < budget), 1);
    idle(3);
  endtask

  int         c_wr, c_en, s0, s1, pk, lc, n, stored, len;
  logic [7:0] frame10 [10];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", n_pass, n_chk);
    $fatal(1);
  end

  initial begin : stim
    frame10 = '{PC_HDR_0, PC_HDR_1, PC_HDR_2, PC_HDR_3, 8'h40, 8'h01, 8'hAA, 8'h55, 8'h12, 8'h34};

    // reset state
    repeat (3) @(negedge clk_sys);
    chk("rst_txd", int'(uart_txd), 1);
    chk("rst_busy", int'(tx_busy), 0);
    chk("rst_level", int'(fifo_level), 0);
    chk("rst_ovf", int'(tx_ovf), 0);
    rst = 1'b0;
    idle(2);

    // single byte, latency and busy
    tx_en = 1'b1;
    s0 = starts.size();
    put(8'hEF, 1); c_wr = cyc;
    idle(10);
    chk("single_busy", int'(tx_busy), 1);
    wait_drain("single_drain", 200);
    chk("single_nstart", starts.size(), s0 + 1);
    if (starts.size() > s0) chk("single_latency", starts[s0] - c_wr, 4);

    // 10-byte frame back to back
    s0 = starts.size(); pk = 0;
    for (int i = 0; i < 10; i++) begin
      put(frame10[i], 1);
      if (int'(fifo_level) > pk) pk = int'(fifo_level);
    end
    for (int i = 0; i < 5; i++) begin
      idle(1);
      if (int'(fifo_level) > pk) pk = int'(fifo_level);
    end
    chk("frame_peak_level", pk, 10 - 1);   // first byte is popped immediately
    wait_drain("frame_drain", 10 * FRAME + 100);
    chk("frame_ovf", int'(tx_ovf), 0);
    chk("frame_nstart", starts.size(), s0 + 10);
    if (starts.size() >= s0 + 10)
      for (int i = 1; i < 10; i++) chk("frame_spacing", starts[s0+i] - starts[s0+i-1], FRAME);

    // overflow with serializer disabled, then clear priority
    tx_en = 1'b0;
    for (int i = 0; i < 20; i++) put(8'(i), i < DEPTH);
    idle(1);
    chk("ovf_level_full", int'(fifo_level), DEPTH);
    chk("ovf_set", int'(tx_ovf), 1);
    @(negedge clk_sys); tx_ovf_clr = 1'b1;
    @(negedge clk_sys); tx_ovf_clr = 1'b0;
    chk("ovf_clr_alone", int'(tx_ovf), 0);
    @(negedge clk_sys); tx_ovf_clr = 1'b1; pc_tx_data = 8'hEE; pc_tx_data_valid = 1'b1;
    @(negedge clk_sys); tx_ovf_clr = 1'b0; pc_tx_data_valid = 1'b0;
    chk("ovf_set_wins", int'(tx_ovf), 1);
    @(negedge clk_sys); tx_ovf_clr = 1'b1;
    @(negedge clk_sys); tx_ovf_clr = 1'b0;
    chk("ovf_clr_next", int'(tx_ovf), 0);
    chk("ovf_level_held", int'(fifo_level), DEPTH);
    tx_en = 1'b1;
    wait_drain("ovf_drain", DEPTH * FRAME + 100);
    chk("ovf_level_empty", int'(fifo_level), 0);

    // randomized fills with tx_en low: accepted = min(n, DEPTH)
    for (int it = 0; it < 3; it++) begin
      tx_en = 1'b0;
      n = $urandom_range(8, 24);
      stored = 0;
      for (int j = 0; j < n; j++) begin
        put(8'($urandom_range(0, 255)), stored < DEPTH);
        if (stored < DEPTH) stored++;
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      idle(1);
      chk("rfill_level", int'(fifo_level), stored);
      chk("rfill_ovf", int'(tx_ovf), int'(n > DEPTH));
      @(negedge clk_sys); tx_ovf_clr = 1'b1;
      idle(1);
      tx_en = 1'b1;
      wait_drain("rfill_drain", DEPTH * FRAME + 100);
      chk("rfill_level_empty", int'(fifo_level), 0);
      chk("rfill_ovf_clr", int'(tx_ovf), 0);
    end

    // randomized bursts while transmitting (never enough to overflow)
    for (int it = 0; it < 6; it++) begin
      len = $urandom_range(1, 12);
      for (int j = 0; j < len; j++) begin
        put(8'($urandom_range(0, 255)), 1);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      idle(1);
      wait_drain("burst_drain", 12 * FRAME + 100);
    end
    chk("burst_ovf", int'(tx_ovf), 0);

    // reset mid-DATA of 0x5A with 3 bytes queued
    put(8'h5A, 1); c_wr = cyc;
    put(8'h11, 1); put(8'h22, 1); put(8'h33, 1);
    idle(1);
    while (cyc < c_wr + 4 + BD + 3 * BD) @(negedge clk_sys);
    @(negedge clk_sys); rst = 1'b1; abort_cnt++; exp_q.delete();
    @(negedge clk_sys); rst = 1'b0;
    chk("mrst_txd", int'(uart_txd), 1);
    chk("mrst_level", int'(fifo_level), 0);
    chk("mrst_busy", int'(tx_busy), 0);
    lc = low_cnt;
    idle(100);
    chk("mrst_no_start", low_cnt, lc);
    chk("mrst_still_idle", int'(tx_busy), 0);

    // tx_en dropped during bit 3 of 0xC3
    put(8'hC3, 1); c_wr = cyc;
    put(8'h3C, 1);
    idle(1);
    while (cyc < c_wr + 4 + BD + 3 * BD + 1) @(negedge clk_sys);
    tx_en = 1'b0;
    while (cyc < c_wr + 3 * FRAME) @(negedge clk_sys);
    chk("hold_c3_sent", exp_q.size(), 1);
    chk("hold_level", int'(fifo_level), 1);
    chk("hold_busy", int'(tx_busy), 1);
    s1 = starts.size();
    @(negedge clk_sys); tx_en = 1'b1; c_en = cyc;
    wait_drain("hold_drain", 2 * FRAME + 100);
    chk("hold_nstart", starts.size(), s1 + 1);
    if (starts.size() > s1) chk("hold_restart_latency", starts[s1] - c_en, 3);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
